// File: rtl/multiplicador_booth.sv
// multiplicador_booth: sequential signed Booth multiplier, p = a * x (2*WIDTH-bit product).
// Latency: WIDTH edges after start is accepted (WIDTH/2 with BOOTH_RADIX4_EN), done pulses one cycle.
// Handshake: start accepted only in IDLE; start while busy or on the done edge is ignored.
// Optional macro BOOTH_RADIX4_EN selects the radix-4 (modified Booth) engine; WIDTH must then be even.
module multiplicador_booth #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     x,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

`ifdef BOOTH_RADIX4_EN
  // Two guard bits so that adding or subtracting 2M never overflows the accumulator.
  localparam int AW    = WIDTH + 2;
  localparam int STEPS = WIDTH / 2;
`else
  // One guard bit so that subtracting the most negative M never overflows.
  localparam int AW    = WIDTH + 1;
  localparam int STEPS = WIDTH;
`endif
  localparam int CW = $clog2(STEPS + 1);

  // Reject unusable parameterisations at elaboration.
  if (WIDTH < 2) begin : g_width_too_small
    $error("multiplicador_booth: WIDTH must be >= 2");
  end
`ifdef BOOTH_RADIX4_EN
  if ((WIDTH % 2) != 0) begin : g_width_odd
    $error("multiplicador_booth: radix-4 engine needs an even WIDTH");
  end
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        m_q, m_d;       // sign-extended multiplicand
  logic [AW-1:0]        acc_q, acc_d;   // partial-product accumulator A
  logic [WIDTH-1:0]     q_q, q_d;       // multiplier / low product half Q
  logic                 qm1_q, qm1_d;   // q_-1
  logic [CW-1:0]        cnt_q, cnt_d;   // completed Booth steps
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 done_q, done_d;

  logic [AW-1:0]        addend;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        acc_sh;
  logic [WIDTH-1:0]     q_sh;
  logic                 qm1_sh;
  logic                 last_step;

  // One Booth step: pick the recoded addend, accumulate, arithmetic-shift {A, Q, q_-1}.
  always_comb begin
    addend = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q_q[1], q_q[0], qm1_q})
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = {m_q[AW-2:0], 1'b0};
      3'b100:         addend = -{m_q[AW-2:0], 1'b0};
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
    sum = acc_q + addend;
    {acc_sh, q_sh, qm1_sh} = {{2{sum[AW-1]}}, sum, q_q[WIDTH-1:1]};
`else
    case ({q_q[0], qm1_q})
      2'b01:   addend = m_q;
      2'b10:   addend = -m_q;
      default: addend = '0;
    endcase
    sum = acc_q + addend;
    {acc_sh, q_sh, qm1_sh} = {sum[AW-1], sum, q_q};
`endif
    last_step = (cnt_q == CW'(STEPS - 1));
  end

  // Next-state and datapath control for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {{(AW-WIDTH){a[WIDTH-1]}}, a};
          acc_d   = '0;
          q_d     = x;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = qm1_sh;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // The shifted value is the product sign-extended; the low 2*WIDTH bits are exact.
          p_d     = {acc_sh[WIDTH-1:0], q_sh};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_multiplicador_booth.sv
// tb_multiplicador_booth: directed and swept checks of multiplicador_booth at WIDTH=4 and WIDTH=8.
// Expected products come from hand values or the bench's own signed multiply.
// Latency expectation follows the build: WIDTH (radix-2) or WIDTH/2 (BOOTH_RADIX4_EN).
module tb_multiplicador_booth;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT4 = 2;
  localparam int LAT8 = 4;
`else
  localparam int LAT4 = 4;
  localparam int LAT8 = 8;
`endif
  localparam int LIMIT = 40;

  logic        clk;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, x4;
  logic [7:0]  a8, x8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int checks;
  int failures;

  multiplicador_booth #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .x(x4),
    .busy(busy4), .done(done4), .p(p4)
  );

  multiplicador_booth #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .x(x8),
    .busy(busy8), .done(done8), .p(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full multiply on the WIDTH=4 instance with latency and product checks.
  task automatic mul4(input logic [3:0] av, input logic [3:0] xv, input logic [7:0] ev,
                      input string tag, input bit full);
    int k;
    @(negedge clk);
    a4 = av; x4 = xv; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    if (full) chk({tag, "_busy_run"}, 64'(busy4), 64'd1);
    k = 0;
    while (done4 !== 1'b1 && k < LIMIT) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(LAT4));
    chk({tag, "_p"}, 64'(p4), 64'(ev));
    if (full) begin
      chk({tag, "_busy_done"}, 64'(busy4), 64'd0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(done4), 64'd0);
      chk({tag, "_p_held"}, 64'(p4), 64'(ev));
    end
  endtask

  // One full multiply on the WIDTH=8 instance.
  task automatic mul8(input logic [7:0] av, input logic [7:0] xv, input logic [15:0] ev,
                      input string tag);
    int k;
    @(negedge clk);
    a8 = av; x8 = xv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    k = 0;
    while (done8 !== 1'b1 && k < LIMIT) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(LAT8));
    chk({tag, "_p"}, 64'(p8), 64'(ev));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int d1;
    int d2;
    logic [7:0]  pa;
    logic [7:0]  pb;
    logic [3:0]  sa, sx;
    logic signed [7:0]  e4;
    logic signed [15:0] e8;
    logic [7:0]  ra, rx;

    checks = 0; failures = 0;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; x4 = '0; a8 = '0; x8 = '0;
    rst = 1'b1;
    #2;
    chk("reset_busy", 64'(busy4), 64'd0);
    chk("reset_done", 64'(done4), 64'd0);
    chk("reset_p", 64'(p4), 64'd0);
    chk("reset_p8", 64'(p8), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed products.
    mul4(4'd7, 4'd3, 8'h15, "m7x3", 1'b1);
    mul4(4'd4, 4'hC, 8'hF0, "m4xm4", 1'b1);
    mul4(4'hD, 4'd5, 8'hF1, "mm3x5", 1'b1);
    mul4(4'hB, 4'hA, 8'h1E, "mm5xm6", 1'b1);
    mul4(4'h8, 4'h8, 8'h40, "mm8xm8", 1'b1);
    mul4(4'h8, 4'd7, 8'hC8, "mm8x7", 1'b1);

    // start while busy is ignored; operand changes do not disturb the run.
    @(negedge clk);
    a4 = 4'd7; x4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    ndone = 0; d1 = 0;
    for (int e = 1; e <= LAT4 + 6; e++) begin
      @(negedge clk);
      if (e <= LAT4 - 1) begin
        start4 = 1'b1; a4 = 4'hB + 4'(e); x4 = 4'hA - 4'(e);
      end else begin
        start4 = 1'b0;
      end
      @(posedge clk); #1;
      if (done4 === 1'b1) begin
        ndone++;
        if (ndone == 1) d1 = e;
      end
    end
    chk("busy_ign_ndone", 64'(ndone), 64'd1);
    chk("busy_ign_edge", 64'(d1), 64'(LAT4));
    chk("busy_ign_p", 64'(p4), 64'h15);
    chk("busy_ign_idle", 64'(busy4), 64'd0);

    // start held high: ignored on the done edge, accepted one edge later.
    @(negedge clk);
    a4 = 4'd7; x4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a4 = 4'hB; x4 = 4'hA;
    ndone = 0; d1 = 0; d2 = 0; pa = '0; pb = '0;
    for (int e = 1; e <= 2 * LAT4 + 4; e++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin
        ndone++;
        if (ndone == 1) begin d1 = e; pa = p4; end
        if (ndone == 2) begin d2 = e; pb = p4; end
      end
      if (e == LAT4 + 1) begin
        chk("b2b_accept_busy", 64'(busy4), 64'd1);
        start4 = 1'b0;
      end
    end
    chk("b2b_ndone", 64'(ndone), 64'd2);
    chk("b2b_edge1", 64'(d1), 64'(LAT4));
    chk("b2b_edge2", 64'(d2), 64'(2 * LAT4 + 1));
    chk("b2b_p1", 64'(pa), 64'h15);
    chk("b2b_p2", 64'(pb), 64'h1E);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a4 = 4'hB; x4 = 4'hA; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy4), 64'd0);
    chk("arst_done", 64'(done4), 64'd0);
    chk("arst_p", 64'(p4), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) ndone++;
    end
    chk("arst_no_done", 64'(ndone), 64'd0);
    chk("arst_p_zero", 64'(p4), 64'd0);
    mul4(4'h8, 4'd7, 8'hC8, "post_rst", 1'b1);

    // Exhaustive WIDTH=4 sweep against the bench's signed product.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        sa = 4'(i); sx = 4'(j);
        e4 = $signed(sa) * $signed(sx);
        mul4(sa, sx, 8'(e4), $sformatf("sweep_%0d_%0d", i, j), 1'b0);
      end
    end

    // WIDTH=8 corners and random vectors.
    mul8(8'h80, 8'h80, 16'h4000, "w8_m128xm128");
    mul8(8'h80, 8'h7F, 16'hC080, "w8_m128x127");
    mul8(8'h7F, 8'h7F, 16'h3F01, "w8_127x127");
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rx = 8'($urandom_range(0, 255));
      e8 = $signed(ra) * $signed(rx);
      mul8(ra, rx, 16'(e8), $sformatf("w8_rand_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
